i2c_target_regbank: RTL and testbench

- Synthesizable I2C target (responder) with an internal 8-bit register bank.
- Forms the other end of the ROM-scripted BME-sensor I2C initiator. Used for loopback bring-up and on-board emulation of the sensor register map, so the master script can run without the physical part.
- Local fabric logic preloads and updates registers, for example chip ID and measurement registers.

---
 rtl/i2c_target_regbank_if.sv | 22 ++
 rtl/i2c_target_regbank.sv | 187 ++++++++++++++++++
 tb/tb_i2c_target_regbank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regbank_if.sv
// Pad-side I2C signals plus the local register-update and commit-notify port of the target.
interface i2c_target_regbank_if #(parameter int REG_AW = 8);
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic              loc_we;
  logic [REG_AW-1:0] loc_addr;
  logic [7:0]        loc_wdata;
  logic              i2c_wr;
  logic [REG_AW-1:0] i2c_wr_addr;
  logic [7:0]        i2c_wr_data;
  logic              busy;

  modport master (
    output scl_in, sda_in, loc_we, loc_addr, loc_wdata,
    input  sda_oe, i2c_wr, i2c_wr_addr, i2c_wr_data, busy
  );
  modport slave (
    input  scl_in, sda_in, loc_we, loc_addr, loc_wdata,
    output sda_oe, i2c_wr, i2c_wr_addr, i2c_wr_data, busy
  );
endinterface

// File: rtl/i2c_target_regbank.sv
// I2C target with a 2**REG_AW x 8 register bank; emulates a sensor register map.
// Assumes REG_AW <= 8 and FILT_LEN >= 2.
module i2c_target_regbank #(
  parameter logic [6:0] DEV_ADDR = 7'h76,
  parameter int         REG_AW   = 8,
  parameter int         FILT_LEN = 3
) (
  input logic             clk,
  input logic             reset,
  i2c_target_regbank_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_P
  } state_e;

  logic [1:0]          scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILT_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                scl_p_q, sda_p_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], bus.scl_in};
    sda_sync_d = {sda_sync_q[0], bus.sda_in};
    scl_hist_d = {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
    // A new level is taken only once the whole history window agrees.
    scl_f_d = scl_f_q;
    if (&scl_hist_q)       scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    sda_f_d = sda_f_q;
    if (&sda_hist_q)       sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [REG_AW-1:0] ptr_q, ptr_inc;
  logic              rw_q, rd_ack_q, sda_oe_q, busy_q;
  logic              i2c_wr_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        mem_q [2**REG_AW];
  logic              byte_done, rx_state;

  assign ptr_inc   = ptr_q + 1'b1;
  assign byte_done = (bit_cnt_q == 4'd8);
  assign rx_state  = (state_q == ADDR) || (state_q == PTR) || (state_q == WR_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      rd_ack_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      i2c_wr_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      i2c_wr_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        if (scl_rise && (rx_state || state_q == RD_DATA)) bit_cnt_q <= bit_cnt_q + 4'd1;
        if (scl_rise && rx_state) shift_q <= {shift_q[6:0], sda_f_q};
        case (state_q)
          ADDR: if (scl_fall && byte_done) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              rw_q     <= shift_q[0];
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            bit_cnt_q <= '0;
            if (rw_q) begin
              state_q  <= RD_DATA;
              shift_q  <= mem_q[ptr_q];
              sda_oe_q <= ~mem_q[ptr_q][7];
            end else begin
              state_q  <= PTR;
              sda_oe_q <= 1'b0;
            end
          end
          PTR: if (scl_fall && byte_done) begin
            state_q  <= PTR_ACK;
            ptr_q    <= shift_q[REG_AW-1:0];
            sda_oe_q <= 1'b1;
          end
          WR_DATA: if (scl_fall && byte_done) begin
            state_q   <= WR_ACK;
            sda_oe_q  <= 1'b1;
            i2c_wr_q  <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= shift_q;
            ptr_q     <= ptr_inc;
          end
          PTR_ACK, WR_ACK: if (scl_fall) begin
            state_q   <= WR_DATA;
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
          end
          RD_DATA: if (scl_fall) begin
            if (byte_done) begin
              state_q  <= RD_ACK;
              sda_oe_q <= 1'b0;
            end else begin
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= ~shift_q[6];
            end
          end
          RD_ACK: begin
            if (scl_rise) rd_ack_q <= ~sda_f_q;
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rd_ack_q) begin
                state_q  <= RD_DATA;
                ptr_q    <= ptr_inc;
                shift_q  <= mem_q[ptr_inc];
                sda_oe_q <= ~mem_q[ptr_inc][7];
              end else begin
                state_q <= WAIT_P;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Commit lands one cycle after the ACK decision; on a same-address clash the I2C byte wins.
  always_ff @(posedge clk) begin
    if (bus.loc_we && !(i2c_wr_q && bus.loc_addr == wr_addr_q))
      mem_q[bus.loc_addr] <= bus.loc_wdata;
    if (i2c_wr_q)
      mem_q[wr_addr_q] <= wr_data_q;
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.busy        = busy_q;
  assign bus.i2c_wr      = i2c_wr_q;
  assign bus.i2c_wr_addr = wr_addr_q;
  assign bus.i2c_wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_target_regbank.sv
// Bit-banged I2C master against the register-bank target; commits and read bytes scoreboarded.
module tb_i2c_target_regbank;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_target_regbank_if #(.REG_AW(8)) bus();
  i2c_target_regbank #(.DEV_ADDR(7'h76), .REG_AW(8), .FILT_LEN(3)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  logic m_scl = 1'b1, m_low = 1'b0, glitch = 1'b0, quiet = 1'b0;
  assign bus.scl_in = m_scl;
  assign bus.sda_in = ~(m_low | bus.sda_oe);

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_exp[$];
  logic [7:0] rd_exp[$];
  int n_tests = 0, n_fail = 0, quiet_viol = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n) begin
      if (bus.i2c_wr) begin
        if (wr_exp.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_exp.pop_front();
          chk("wr_addr", bus.i2c_wr_addr, e.a);
          chk("wr_data", bus.i2c_wr_data, e.d);
        end
      end
      if (quiet && (bus.sda_oe || bus.busy)) quiet_viol++;
    end
  end

  task automatic tick(input int n); repeat (n) @(posedge clk); endtask

  task automatic bstart();
    m_low = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic bstop();
    m_low = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
  endtask

  task automatic wbit(input logic b);
    m_low = ~b; tick(Q); m_scl = 1'b1;
    if (glitch) begin
      tick(Q/2); m_low = ~m_low; tick(1); m_low = ~m_low; tick(Q + Q/2 - 1);
    end else tick(2*Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); #1 b = bus.sda_in; tick(Q); m_scl = 1'b0; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(a);
    chk(tag, (a == 1'b0), exp_ack);
  endtask

  task automatic rbyte(input logic [7:0] e, input logic send_ack);
    logic [7:0] d;
    logic b;
    d = '0;
    rd_exp.push_back(e);
    for (int i = 0; i < 8; i++) begin rbit(b); d = {d[6:0], b}; end
    wbit(!send_ack);
    chk("rd_data", d, rd_exp.pop_front());
  endtask

  task automatic lwr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); bus.loc_we = 1'b1; bus.loc_addr = a; bus.loc_wdata = d;
    @(negedge clk); bus.loc_we = 1'b0;
  endtask

  task automatic set_ptr_sr(input logic [7:0] p);
    bstart(); wbyte(8'hEC, 1'b1, "ack_aw"); wbyte(p, 1'b1, "ack_ptr");
    bstart(); wbyte(8'hED, 1'b1, "ack_ar");
  endtask

  initial begin
    bit seen;
    bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_wdata = '0;
    tick(3);
    @(negedge clk);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_i2c_wr", bus.i2c_wr, 0);
    chk("rst_wr_addr", bus.i2c_wr_addr, 0);
    chk("rst_wr_data", bus.i2c_wr_data, 0);
    rst_n = 1'b1;
    tick(10);

    // chip-id style read via pointer write + repeated START
    lwr(8'hD0, 8'h60);
    bstart(); wbyte(8'hEC, 1'b1, "ack_aw"); wbyte(8'hD0, 1'b1, "ack_ptr");
    chk("busy_mid", bus.busy, 1);
    bstart(); wbyte(8'hED, 1'b1, "ack_ar");
    rbyte(8'h60, 1'b0);
    bstop(); tick(10);
    chk("busy_after_p", bus.busy, 0);

    // two-byte write with auto-increment, then read back
    wr_exp.push_back('{8'hF4, 8'h27});
    wr_exp.push_back('{8'hF5, 8'h55});
    bstart(); wbyte(8'hEC, 1'b1, "ack_aw"); wbyte(8'hF4, 1'b1, "ack_ptr");
    wbyte(8'h27, 1'b1, "ack_d0"); wbyte(8'h55, 1'b1, "ack_d1");
    bstop(); tick(10);
    chk("wr_pending", wr_exp.size(), 0);
    set_ptr_sr(8'hF4); rbyte(8'h27, 1'b1); rbyte(8'h55, 1'b0); bstop(); tick(10);

    // burst read across the 0xFF -> 0x00 wrap
    lwr(8'hFE, 8'h11); lwr(8'hFF, 8'h22); lwr(8'h00, 8'h33);
    set_ptr_sr(8'hFE);
    rbyte(8'h11, 1'b1); rbyte(8'h22, 1'b1); rbyte(8'h33, 1'b0);
    bstop(); tick(10);

    // foreign address: no ACK, no busy, no commit
    quiet = 1'b1;
    bstart(); wbyte(8'hEE, 1'b0, "nack_addr"); wbyte(8'hF4, 1'b0, "nack_ptr");
    wbyte(8'h99, 1'b0, "nack_dat");
    bstop(); tick(10);
    quiet = 1'b0;
    chk("quiet_viol", quiet_viol, 0);
    set_ptr_sr(8'hF4); rbyte(8'h27, 1'b0); bstop(); tick(10);

    // short SDA glitches while SCL high must not look like START/STOP
    wr_exp.push_back('{8'h10, 8'hA5});
    glitch = 1'b1;
    bstart(); wbyte(8'hEC, 1'b1, "g_ack_aw"); wbyte(8'h10, 1'b1, "g_ack_ptr");
    wbyte(8'hA5, 1'b1, "g_ack_d");
    glitch = 1'b0;
    bstop(); tick(10);
    chk("g_wr_pending", wr_exp.size(), 0);
    set_ptr_sr(8'h10); rbyte(8'hA5, 1'b0); bstop(); tick(10);

    // reset while target is driving the address ACK
    bstart();
    for (int i = 7; i >= 0; i--) wbit(logic'((8'hEC >> i) & 1));
    m_low = 1'b0; tick(Q); m_scl = 1'b1; tick(Q);
    #1 chk("ack_before_rst", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sda_oe", bus.sda_oe, 0);
    chk("rst_mid_busy", bus.busy, 0);
    tick(2); #1 rst_n = 1'b1;
    tick(Q); m_scl = 1'b0; tick(Q);
    bstop(); tick(10);
    set_ptr_sr(8'hD0); rbyte(8'h60, 1'b0); bstop(); tick(10);

    // local write colliding with an I2C commit to the same register
    wr_exp.push_back('{8'hF4, 8'h77});
    seen = 1'b0;
    fork
      begin
        bstart(); wbyte(8'hEC, 1'b1, "c_ack_aw"); wbyte(8'hF4, 1'b1, "c_ack_ptr");
        wbyte(8'h77, 1'b1, "c_ack_d"); bstop(); tick(10);
      end
      begin
        for (int i = 0; i < 20000 && !seen; i++) begin
          @(negedge clk);
          if (bus.i2c_wr) seen = 1'b1;
        end
        if (seen) begin
          bus.loc_we = 1'b1; bus.loc_addr = 8'hF4; bus.loc_wdata = 8'hAA;
          @(negedge clk); bus.loc_we = 1'b0;
        end
      end
    join
    chk("collide_seen", seen, 1);
    set_ptr_sr(8'hF4); rbyte(8'h77, 1'b0); bstop(); tick(10);
    chk("wr_left", wr_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
